// File: rtl/inputdata_pkg.sv
`default_nettype none
// ============================================================================
// Module      : inputdata_pkg
// Description : Shared types and constants for the inputdata producer.
// Revision    : 1.0 - initial release
// ============================================================================
package inputdata_pkg;

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } hold_state_t;

    localparam int c_default_data_width = 8;

endpackage : inputdata_pkg
`default_nettype wire

// File: rtl/serial_word_shifter.sv
`default_nettype none
// ============================================================================
// Module      : serial_word_shifter
// Description : MSB-first serial-to-parallel shifter with word-complete pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_word_shifter
    import inputdata_pkg::*;
#(
    parameter int DATA_WIDTH = c_default_data_width
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  serial_in,
    input  logic                  serial_valid,
    output logic [DATA_WIDTH-1:0] word,
    output logic                  word_done
);

    localparam int                 c_cnt_w = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(DATA_WIDTH - 1);

    generate
        if (DATA_WIDTH < 2) begin : g_width_check
            $error("serial_word_shifter: DATA_WIDTH must be 2 or more");
        end
    endgenerate

    // The top bit of the word is never needed after the completing edge,
    // so only DATA_WIDTH-1 bits of history are kept.
    logic [DATA_WIDTH-2:0] r_shift;
    logic [c_cnt_w-1:0]    r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shift <= '0;
            r_count <= '0;
        end else if (serial_valid) begin
            r_shift <= word[DATA_WIDTH-2:0];
            r_count <= (r_count == c_last) ? '0 : r_count + 1'b1;
        end
    end

    assign word      = {r_shift, serial_in};
    assign word_done = serial_valid && (r_count == c_last);

endmodule : serial_word_shifter
`default_nettype wire

// File: rtl/inputdata_source.sv
`default_nettype none
// ============================================================================
// Module      : inputdata_source
// Description : Serial word producer for the loaddata/inputdata_ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module inputdata_source
    import inputdata_pkg::*;
#(
    parameter int DATA_WIDTH = c_default_data_width
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  serial_in,
    input  logic                  serial_valid,
    input  logic                  loaddata,
    output logic                  inputdata_ready,
    output logic [DATA_WIDTH-1:0] inputdata,
    output logic                  overrun
);

    hold_state_t           r_state;
    logic [DATA_WIDTH-1:0] w_word;
    logic                  w_word_done;
    logic                  w_transfer;

    serial_word_shifter #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_shifter (
        .clk          (clk),
        .reset        (reset),
        .serial_in    (serial_in),
        .serial_valid (serial_valid),
        .word         (w_word),
        .word_done    (w_word_done)
    );

    assign w_transfer      = inputdata_ready && loaddata;
    assign inputdata_ready = (r_state == FULL);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= EMPTY;
            inputdata <= '0;
            overrun   <= 1'b0;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_word_done) begin
                        r_state   <= FULL;
                        inputdata <= w_word;
                    end
                end
                FULL: begin
                    // A word completing on the transfer edge refills the slot directly.
                    if (w_transfer) begin
                        if (w_word_done) begin
                            inputdata <= w_word;
                        end else begin
                            r_state <= EMPTY;
                        end
                    end else if (w_word_done) begin
                        overrun <= 1'b1;
                    end
                end
                default: r_state <= EMPTY;
            endcase
        end
    end

endmodule : inputdata_source
`default_nettype wire
